// File: rtl/module_bcd_display.sv
// Two-digit 7-segment display driver: a 7-bit value is saturated to 99, converted
// to BCD by a sequential double-dabble, and shown one digit at a time as selected.
//
// state  | meaning
// IDLE   | waiting for a value; in_ready asserted one cycle after entry
// CONV   | seven double-dabble iterations on the shift register
// COMMIT | copy BCD result and overflow flag into the display registers
module module_bcd_display #(
    parameter bit BLANK_LZ       = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [6:0] in_data,
    output logic       in_ready,
    input  logic       load_u,
    input  logic       load_d,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       busy,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t      state;
    logic [14:0] shreg;
    logic [2:0]  iter;
    logic        ovf_pend;
    logic [3:0]  units;
    logic [3:0]  tens;
    logic [6:0]  seg_on;
    logic [1:0]  an_on;
    logic [6:0]  sat_data;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'b1111110;
            4'd1:    c = 7'b0110000;
            4'd2:    c = 7'b1101101;
            4'd3:    c = 7'b1111001;
            4'd4:    c = 7'b0110011;
            4'd5:    c = 7'b1011011;
            4'd6:    c = 7'b1011111;
            4'd7:    c = 7'b1110000;
            4'd8:    c = 7'b1111111;
            4'd9:    c = 7'b1111011;
            default: c = 7'b0000000;
        endcase
        return c;
    endfunction

    function automatic logic [14:0] dabble_step(input logic [14:0] r);
        logic [3:0] t;
        logic [3:0] u;
        t = r[14:11];
        u = r[10:7];
        if (t >= 4'd5) t = t + 4'd3;
        if (u >= 4'd5) u = u + 4'd3;
        return {t, u, r[6:0]} << 1;
    endfunction

    assign sat_data = (in_data > 7'd99) ? 7'd99 : in_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            shreg    <= '0;
            iter     <= '0;
            ovf_pend <= 1'b0;
            units    <= '0;
            tens     <= '0;
            ovf      <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_ready && in_valid) begin
                        shreg    <= {8'd0, sat_data};
                        ovf_pend <= (in_data > 7'd99);
                        iter     <= '0;
                        state    <= CONV;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                CONV: begin
                    shreg <= dabble_step(shreg);
                    iter  <= iter + 3'd1;
                    if (iter == 3'd6) state <= COMMIT;
                end
                COMMIT: begin
                    units <= shreg[10:7];
                    tens  <= shreg[14:11];
                    ovf   <= ovf_pend;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

    // Digit selection in active-high terms; polarity is applied at the register.
    always_comb begin
        seg_on = '0;
        an_on  = '0;
        if (load_u && !load_d) begin
            an_on  = 2'b01;
            seg_on = seg_code(units);
        end else if (!load_u && load_d && !(BLANK_LZ && (tens == 4'd0))) begin
            an_on  = 2'b10;
            seg_on = seg_code(tens);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            seg <= {7{SEG_ACTIVE_LOW}};
            an  <= {2{AN_ACTIVE_LOW}};
        end else begin
            seg <= seg_on ^ {7{SEG_ACTIVE_LOW}};
            an  <= an_on ^ {2{AN_ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_module_bcd_display.sv
// Bench for module_bcd_display: timeline model of accept/convert/commit plus
// digit-select decoding, compared every cycle, with directed literal checks.
module tb_module_bcd_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic [6:0] in_data = '0;
    logic       in_ready;
    logic       load_u = 1'b0;
    logic       load_d = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       busy;
    logic       ovf;

    always #5 clk = ~clk;

    module_bcd_display dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .load_u   (load_u),
        .load_d   (load_d),
        .seg      (seg),
        .an       (an),
        .busy     (busy),
        .ovf      (ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Active-high segment patterns a..g for digits 0..9
    logic [6:0] codes [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011};

    bit         started = 1'b0;
    int         phase = 0;
    bit         m_ready = 1'b0;
    bit         m_busy = 1'b0;
    bit         m_ovf = 1'b0;
    int         m_units = 0;
    int         m_tens = 0;
    int         p_val = 0;
    bit         p_ovf = 1'b0;
    logic [1:0] m_an = 2'b11;
    logic [6:0] m_seg = 7'h7f;

    // phase counts edges since the accepting edge; commit lands on the 8th, ready on the 9th
    always @(posedge clk) begin
        if (!rst) begin
            started = 1'b1;
            phase   = 0;
            m_ready = 1'b0;
            m_busy  = 1'b0;
            m_ovf   = 1'b0;
            m_units = 0;
            m_tens  = 0;
            m_an    = 2'b11;
            m_seg   = 7'h7f;
        end else begin
            m_an  = 2'b11;
            m_seg = 7'h7f;
            if (load_u && !load_d) begin
                m_an  = 2'b10;
                m_seg = ~codes[m_units];
            end else if (load_d && !load_u && m_tens != 0) begin
                m_an  = 2'b01;
                m_seg = ~codes[m_tens];
            end
            if (phase == 0) begin
                if (m_ready && in_valid) begin
                    p_val   = (int'(in_data) > 99) ? 99 : int'(in_data);
                    p_ovf   = (int'(in_data) > 99);
                    phase   = 1;
                    m_ready = 1'b0;
                    m_busy  = 1'b1;
                end else begin
                    m_ready = 1'b1;
                end
            end else begin
                phase++;
                if (phase == 9) begin
                    m_units = p_val % 10;
                    m_tens  = p_val / 10;
                    m_ovf   = p_ovf;
                    m_busy  = 1'b0;
                end else if (phase == 10) begin
                    phase   = 0;
                    m_ready = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_in_ready", int'(in_ready), int'(m_ready));
            check("model_busy", int'(busy), int'(m_busy));
            check("model_ovf", int'(ovf), int'(m_ovf));
            check("model_an", int'(an), int'(m_an));
            check("model_seg", int'(seg), int'(m_seg));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input int v);
        int t;
        logic [31:0] vv;
        t  = 0;
        vv = v;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("ready_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = vv[6:0];
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int b;
        rst = 1'b0;
        cyc(2);
        check("rst_an", int'(an), 3);
        check("rst_seg", int'(seg), 7'b1111111);
        check("rst_ovf", int'(ovf), 0);
        check("rst_in_ready", int'(in_ready), 0);
        rst = 1'b1;
        cyc(1);
        check("first_ready", int'(in_ready), 1);

        load_u = 1'b1;
        load_d = 1'b0;
        send(42);
        b = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) b++;
            @(negedge clk);
        end
        check("busy_cycles", b, 8);
        check("d42_units_an", int'(an), 2'b10);
        check("d42_units_seg", int'(seg), 7'b0010010);
        load_u = 1'b0;
        load_d = 1'b1;
        cyc(2);
        check("d42_tens_an", int'(an), 2'b01);
        check("d42_tens_seg", int'(seg), 7'b1001100);

        send(7);
        cyc(12);
        check("d7_blank_an", int'(an), 2'b11);
        check("d7_blank_seg", int'(seg), 7'b1111111);
        load_u = 1'b1;
        load_d = 1'b0;
        cyc(2);
        check("d7_units_seg", int'(seg), 7'b0001111);

        send(120);
        cyc(12);
        check("ovf_set", int'(ovf), 1);
        check("sat_units_seg", int'(seg), 7'b0000100);
        load_u = 1'b0;
        load_d = 1'b1;
        cyc(2);
        check("sat_tens_an", int'(an), 2'b01);
        check("sat_tens_seg", int'(seg), 7'b0000100);
        send(5);
        cyc(12);
        check("ovf_clear", int'(ovf), 0);

        load_u = 1'b1;
        load_d = 1'b0;
        send(42);
        in_valid = 1'b1;
        in_data  = 7'd55;
        for (int k = 1; k <= 11; k++) begin
            if (k == 4) in_valid = 1'b0;
            if (k == 9) check("ready_low_e8", int'(in_ready), 0);
            if (k == 10) check("ready_high_e9", int'(in_ready), 1);
            @(negedge clk);
        end
        cyc(1);
        check("ignore55_seg", int'(seg), 7'b0010010);

        send(88);
        cyc(3);
        rst = 1'b0;
        cyc(1);
        rst = 1'b1;
        check("abort_ready", int'(in_ready), 0);
        check("abort_an", int'(an), 2'b11);
        cyc(1);
        check("abort_ready_back", int'(in_ready), 1);
        cyc(12);
        check("abort_busy", int'(busy), 0);
        check("abort_units_seg", int'(seg), 7'b0000001);
        check("abort_units_an", int'(an), 2'b10);

        for (int i = 0; i < 600; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 7'($urandom_range(0, 127));
            load_u   = 1'($urandom_range(0, 1));
            load_d   = 1'($urandom_range(0, 1));
            rst      = ($urandom_range(0, 63) != 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst      = 1'b1;
        cyc(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
